// File: rtl/i2c_pkg.sv
// Shared encodings for the i2c arbiter: master state codes, arbiter FSM states
// and direction constants.
package i2c_pkg;

    localparam logic [2:0] M_IDLE  = 3'd0;
    localparam logic [2:0] M_ADDR  = 3'd1;
    localparam logic [2:0] M_WAIT  = 3'd2;
    localparam logic [2:0] M_READ  = 3'd3;
    localparam logic [2:0] M_WRITE = 3'd4;
    localparam logic [2:0] M_DONE  = 3'd5;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    typedef enum logic [2:0] {
        ARB,
        LAUNCH,
        START,
        BUSY,
        FINISH
    } arb_state_e;

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping at NREQ. Returns a one-hot pick and a valid flag.
module i2c_rr_picker #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] pick_o,
    output logic            valid_o
);

    logic [PW-1:0] idx;

    always_comb begin
        pick_o  = '0;
        valid_o = 1'b0;
        idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = PW'((int'(ptr_i) + i) % NREQ);
            if (!valid_o && req_i[idx]) begin
                pick_o[idx] = 1'b1;
                valid_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c byte master between NREQ clients.
// Optional abort on a hung bus when I2C_ARB_TIMEOUT_EN is defined.
module i2c_arbiter
    import i2c_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic [7:0]        rdata,
    output logic              m_rst,
    output logic              m_rw,
    output logic [7:0]        m_wdata,
    input  logic [7:0]        m_rdata,
    input  logic [2:0]        m_state
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 16) begin : g_param_chk
        $error("i2c_arbiter: NREQ must be 2..8 and TIMEOUT >= 16");
    end

    arb_state_e      state_q;
    logic [NREQ-1:0] gnt_q, done_q;
    logic [7:0]      rdata_q, wdata_q;
    logic            m_rst_q, rw_q;
    logic [PW-1:0]   owner_q, ptr_q, pick_idx, next_ptr;
    logic [NREQ-1:0] pick;
    logic            pick_vld;
    logic            fin_ok, in_txn;

    i2c_rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .valid_o (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++)
            if (pick[i]) pick_idx = PW'(i);
    end

    assign next_ptr = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
    assign fin_ok   = (state_q == FINISH) && (m_state == M_IDLE);
    assign in_txn   = (state_q == START) || (state_q == BUSY) || (state_q == FINISH);

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);
    logic [CW-1:0]   cnt_q;
    logic [NREQ-1:0] err_q;
    logic            tmo;

    // The LAUNCH cycle itself counts, so err lands exactly TIMEOUT cycles after LAUNCH.
    assign tmo = in_txn && (cnt_q == CW'(TIMEOUT - 2));
    assign err = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt_q <= '0;
        else if (state_q == LAUNCH)  cnt_q <= '0;
        else if (in_txn && !tmo)     cnt_q <= cnt_q + CW'(1);
    end
`else
    assign err = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            m_rst_q <= 1'b1;
            rw_q    <= WRITE;
            wdata_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q   <= '0;
`endif
        end else begin
            done_q <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
            err_q  <= '0;
`endif
            case (state_q)
                ARB: if (pick_vld) begin
                    gnt_q   <= pick;
                    owner_q <= pick_idx;
                    rw_q    <= req_rw[pick_idx];
                    wdata_q <= req_wdata[{pick_idx, 3'b000} +: 8];
                    state_q <= LAUNCH;
                end
                LAUNCH: begin
                    m_rst_q <= 1'b0;
                    state_q <= START;
                end
                START:  if (m_state != M_IDLE) state_q <= BUSY;
                BUSY:   if (m_state == M_DONE) state_q <= FINISH;
                FINISH: if (fin_ok) begin
                    if (rw_q == READ) rdata_q <= m_rdata;
                    done_q  <= gnt_q;
                    gnt_q   <= '0;
                    m_rst_q <= 1'b1;
                    ptr_q   <= next_ptr;
                    state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
`ifdef I2C_ARB_TIMEOUT_EN
            // A completion seen in the same cycle wins over the abort.
            if (tmo && !fin_ok) begin
                err_q   <= gnt_q;
                gnt_q   <= '0;
                m_rst_q <= 1'b1;
                ptr_q   <= next_ptr;
                state_q <= ARB;
            end
`endif
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign m_rst   = m_rst_q;
    assign m_rw    = rw_q;
    assign m_wdata = wdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter; the master is modelled by hand-driven m_state.
// Timeout checks are active when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req_rw, gnt, done, err;
    logic [31:0] req_wdata;
    logic [7:0]  rdata, m_wdata, m_rdata;
    logic        m_rst, m_rw;
    logic [2:0]  m_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2c_arbiter #(.NREQ(4), .TIMEOUT(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_rw    (req_rw),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .m_rst     (m_rst),
        .m_rw      (m_rw),
        .m_wdata   (m_wdata),
        .m_rdata   (m_rdata),
        .m_state   (m_state)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Master walks one byte transaction; done is visible on return.
    task automatic master_seq(input logic rd, input logic [7:0] d);
        m_rdata = d;
        m_state = 3'd1; cyc(1);
        m_state = 3'd2; cyc(1);
        m_state = rd ? 3'd3 : 3'd4; cyc(1);
        m_state = 3'd5; cyc(1);
        m_state = 3'd0; cyc(1);
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req_rw = '0; req_wdata = '0;
        m_rdata = '0; m_state = '0;

        // 1. reset values
        cyc(5);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_mrst", 32'(m_rst), 32'h1);
        chk("rst_mrw", 32'(m_rw), 32'h0);
        chk("rst_mwdata", 32'(m_wdata), 32'h0);
        rst_n = 1'b1;

        // 2. single write from client 0
        req = 4'b0001; req_rw = 4'b0000; req_wdata = 32'h0000_00A5;
        cyc(1);
        chk("wr_gnt", 32'(gnt), 32'h1);
        chk("wr_mwdata", 32'(m_wdata), 32'hA5);
        chk("wr_mrw", 32'(m_rw), 32'h0);
        chk("wr_mrst_launch", 32'(m_rst), 32'h1);
        req_wdata = 32'h0000_00FF;
        cyc(1);
        chk("wr_mrst_start", 32'(m_rst), 32'h0);
        chk("wr_mwdata_hold", 32'(m_wdata), 32'hA5);
        master_seq(1'b0, 8'h77);
        chk("wr_done", 32'(done), 32'h1);
        chk("wr_rdata", 32'(rdata), 32'h0);
        chk("wr_gnt_clr", 32'(gnt), 32'h0);
        chk("wr_mrst_fin", 32'(m_rst), 32'h1);
        req = '0;
        cyc(1);
        chk("wr_done_1cyc", 32'(done), 32'h0);

        // 3. single read from client 2
        req = 4'b0100; req_rw = 4'b0100;
        cyc(1);
        chk("rd_gnt", 32'(gnt), 32'h4);
        chk("rd_mrw", 32'(m_rw), 32'h1);
        cyc(1);
        master_seq(1'b1, 8'h3C);
        chk("rd_done", 32'(done), 32'h4);
        chk("rd_rdata", 32'(rdata), 32'h3C);
        req = '0; m_rdata = 8'h99;
        cyc(10);
        chk("rd_rdata_hold", 32'(rdata), 32'h3C);
        chk("rd_done_low", 32'(done), 32'h0);

        // 4. round-robin from pointer 0 with all clients requesting
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
        chk("rr_rdata_rst", 32'(rdata), 32'h0);
        req = 4'b1111; req_rw = 4'b0000; req_wdata = 32'h4433_2211;
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            chk($sformatf("rr_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
            chk($sformatf("rr_wdata%0d", k), 32'(m_wdata), 32'((k % 4) + 1) * 32'h11);
            cyc(1);
            master_seq(1'b0, 8'h00);
            chk($sformatf("rr_done%0d", k), 32'(done), 32'(4'b0001 << (k % 4)));
            chk($sformatf("rr_gnt_off%0d", k), 32'(gnt), 32'h0);
        end

        // 5. hung master: client 1 owns the bus next
        cyc(1);
        chk("hung_gnt", 32'(gnt), 32'h2);
        m_state = 3'd2;
        cyc(31);
        chk("hung_err_early", 32'(err), 32'h0);
        chk("hung_gnt_held", 32'(gnt), 32'h2);
        m_state = 3'd6;
`ifdef I2C_ARB_TIMEOUT_EN
        cyc(1);
        chk("tmo_err", 32'(err), 32'h2);
        chk("tmo_mrst", 32'(m_rst), 32'h1);
        chk("tmo_gnt", 32'(gnt), 32'h0);
        chk("tmo_done", 32'(done), 32'h0);
        m_state = 3'd0;
        cyc(1);
        chk("tmo_err_1cyc", 32'(err), 32'h0);
`else
        cyc(9);
        chk("hung_unknown_gnt", 32'(gnt), 32'h2);
        chk("hung_unknown_done", 32'(done), 32'h0);
        chk("hung_no_err", 32'(err), 32'h0);
        m_state = 3'd5; cyc(1);
        m_state = 3'd0; cyc(1);
        chk("hung_done", 32'(done), 32'h2);
        cyc(1);
`endif
        chk("after_hung_gnt", 32'(gnt), 32'h4);

        // 6. reset mid-BUSY, then a client drops req mid-transaction
        cyc(1);
        m_state = 3'd1; cyc(1);
        m_state = 3'd2; cyc(1);
        rst_n = 1'b0; #1;
        chk("midrst_gnt", 32'(gnt), 32'h0);
        chk("midrst_mrst", 32'(m_rst), 32'h1);
        chk("midrst_done", 32'(done), 32'h0);
        m_state = 3'd0;
        cyc(1);
        rst_n = 1'b1;
        chk("midrst_done_after", 32'(done), 32'h0);
        cyc(1);
        chk("midrst_next_gnt", 32'(gnt), 32'h1);
        cyc(1);
        req = 4'b0000;
        master_seq(1'b0, 8'h00);
        chk("drop_done", 32'(done), 32'h1);
        chk("drop_err", 32'(err), 32'h0);
        cyc(2);
        chk("drop_idle_gnt", 32'(gnt), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
